sine_capture_buffer: RTL and testbench

//  Triggered two-channel capture stage downstream of the dual-output sine generator.

---
 rtl/sine_capture_buffer.sv | 120 ++++++++++++
 tb/tb_sine_capture_buffer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_capture_buffer.sv
// Triggered two-channel capture buffer for the dual-output sine generator.
// Arms on request, triggers on a rising ch1 crossing, stores DEPTH pairs, replays over valid/ready.
module sine_capture_buffer #(
    parameter int D_WIDTH = 8,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               arm,
    input  logic [D_WIDTH-1:0] trig_level,
    input  logic [D_WIDTH-1:0] din1,
    input  logic [D_WIDTH-1:0] din2,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [D_WIDTH-1:0] rd_data1,
    output logic [D_WIDTH-1:0] rd_data2,
    output logic               rd_last,
    output logic               busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_READOUT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic               r_prev_valid;
    logic [D_WIDTH-1:0] r_prev;
    logic               r_rd_valid;
    logic [D_WIDTH-1:0] r_mem1 [DEPTH];
    logic [D_WIDTH-1:0] r_mem2 [DEPTH];

    logic               w_armed;
    logic               w_trigger;
    logic               w_cap_wr;
    logic               w_wr_en;
    logic [AW-1:0]      w_wr_addr;
    logic               w_xfer;
    logic               w_at_last;

    assign w_armed   = (r_state == S_ARMED);
    // Needs a valid previous sample so the first sample after arming can never trigger.
    assign w_trigger = w_armed && en && r_prev_valid &&
                       (r_prev < trig_level) && (din1 >= trig_level);
    assign w_cap_wr  = (r_state == S_CAPTURE) && en;
    assign w_wr_en   = w_trigger || w_cap_wr;
    assign w_wr_addr = w_trigger ? '0 : r_wr_ptr;
    assign w_xfer    = r_rd_valid && rd_ready;
    assign w_at_last = (r_rd_ptr == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (arm) w_state_next = S_ARMED;
            S_ARMED:   if (w_trigger) w_state_next = S_CAPTURE;
            S_CAPTURE: if (w_cap_wr && (r_wr_ptr == LAST_IDX)) w_state_next = S_READOUT;
            S_READOUT: if (w_xfer && w_at_last) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_prev_valid <= 1'b0;
            r_prev       <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_rd_valid <= (w_state_next == S_READOUT);
            if ((r_state == S_IDLE) && arm) begin
                r_prev_valid <= 1'b0;
            end
            if (w_armed && en) begin
                r_prev       <= din1;
                r_prev_valid <= 1'b1;
            end
            if (w_trigger) begin
                r_wr_ptr <= PTR_ONE;
            end else if (w_cap_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_xfer) begin
                r_rd_ptr <= w_at_last ? '0 : (r_rd_ptr + PTR_ONE);
            end
        end
    end

    // Sample storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem1[w_wr_addr] <= din1;
            r_mem2[w_wr_addr] <= din2;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data1 = r_rd_valid ? r_mem1[r_rd_ptr] : '0;
    assign rd_data2 = r_rd_valid ? r_mem2[r_rd_ptr] : '0;
    assign rd_last  = r_rd_valid && w_at_last;
    assign busy     = (r_state == S_ARMED) || (r_state == S_CAPTURE);

endmodule

// File: tb/tb_sine_capture_buffer.sv
// Self-checking bench for sine_capture_buffer: randomized streams against a list-based trigger model.
module tb_sine_capture_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          arm;
    logic [DW-1:0] trig_level;
    logic [DW-1:0] din1;
    logic [DW-1:0] din2;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;
    logic          rd_last;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // stimulus per cycle, and the enabled samples actually presented since arming
    bit            s_en[$];
    logic [DW-1:0] s_d1[$], s_d2[$], s_lv[$];
    logic [DW-1:0] q1[$], q2[$], ql[$];
    logic [DW-1:0] r1[$], r2[$];
    bit            rl[$];

    sine_capture_buffer #(.D_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .arm(arm), .trig_level(trig_level),
        .din1(din1), .din2(din2), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_last(rd_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim();
        s_en.delete(); s_d1.delete(); s_d2.delete(); s_lv.delete();
    endtask

    task automatic add_stim(input bit e, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                            input logic [DW-1:0] lv);
        s_en.push_back(e); s_d1.push_back(d1); s_d2.push_back(d2); s_lv.push_back(lv);
    endtask

    task automatic do_arm();
        en = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        q1.delete(); q2.delete(); ql.delete();
    endtask

    // Applies the stimulus list until rd_valid appears or the list runs out.
    task automatic drive_capture(input bit rand_arm, output bit got_valid, output int n_at_valid);
        got_valid = 1'b0; n_at_valid = 0;
        for (int i = 0; i < s_en.size(); i++) begin
            en = s_en[i]; din1 = s_d1[i]; din2 = s_d2[i]; trig_level = s_lv[i];
            arm = rand_arm ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (en) begin
                q1.push_back(din1); q2.push_back(din2); ql.push_back(trig_level);
            end
            tick();
            if (rd_valid) begin
                got_valid = 1'b1; n_at_valid = q1.size();
                break;
            end
        end
        en = 1'b0; arm = 1'b0;
    endtask

    // Trigger index in the enabled-sample list: first rising crossing with a valid predecessor.
    function automatic int find_trig();
        for (int i = 1; i < q1.size(); i++)
            if (q1[i-1] < ql[i] && q1[i] >= ql[i]) return i;
        return -1;
    endfunction

    task automatic read_all(input int ready_pct, input bit noise, output int stall_err,
                            output bit timed_out);
        logic [DW-1:0] h1, h2;
        bit hl, held;
        r1.delete(); r2.delete(); rl.delete();
        stall_err = 0; timed_out = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            rd_ready = ($urandom_range(0, 99) < ready_pct);
            if (noise) begin
                en = 1'($urandom_range(0, 1)); din1 = 8'($urandom); din2 = 8'($urandom);
                arm = ($urandom_range(0, 2) == 0);
            end
            held = rd_valid && !rd_ready;
            h1 = rd_data1; h2 = rd_data2; hl = rd_last;
            if (rd_valid && rd_ready) begin
                r1.push_back(rd_data1); r2.push_back(rd_data2); rl.push_back(rd_last);
            end
            tick();
            if (held && (!rd_valid || rd_data1 !== h1 || rd_data2 !== h2 || rd_last !== hl))
                stall_err++;
            if (r1.size() == DEPTH) begin
                timed_out = 1'b0;
                break;
            end
        end
        rd_ready = 1'b0; en = 1'b0; arm = 1'b0;
    endtask

    task automatic test_reset();
        bit gv; int n, hi_cnt;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_last !== 1'b0 || busy !== 1'b0 || rd_data1 !== 8'h00 || rd_data2 !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b last=%b busy=%b d1=%h d2=%h, want all 0",
                     rd_valid, rd_last, busy, rd_data1, rd_data2);
        end
        tick(); tick();
        rst = 1'b0;
        hi_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rd_valid !== 1'b0 || busy !== 1'b0) hi_cnt++;
        end
        checks++;
        if (hi_cnt != 0) begin
            failures++;
            $display("FAIL idle_no_arm: got %0d cycles with valid/busy high, want 0", hi_cnt);
        end
        clear_stim();
        for (int v = 8'h70; v <= 8'h90; v++) add_stim(1'b1, 8'(v), ~8'(v), 8'h80);
        do_arm();
        drive_capture(1'b0, gv, n);
        checks++;
        if (rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_readout: got rd_valid=%b, want 1", rd_valid);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_last !== 1'b0 || busy !== 1'b0 || rd_data1 !== 8'h00 || rd_data2 !== 8'h00) begin
            failures++;
            $display("FAIL reset_midcycle: got valid=%b last=%b busy=%b d1=%h d2=%h, want all 0",
                     rd_valid, rd_last, busy, rd_data1, rd_data2);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ramp();
        bit gv, to; int n, t, se;
        clear_stim();
        for (int v = 8'h70; v <= 8'h90; v++) add_stim(1'b1, 8'(v), ~8'(v), 8'h80);
        do_arm();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ramp_busy: got busy=%b, want 1", busy);
        end
        drive_capture(1'b0, gv, n);
        t = find_trig();
        checks++;
        if (!gv || t < 0 || n != t + DEPTH) begin
            failures++;
            $display("FAIL ramp_latency: got valid=%b at sample %0d, want 1 at sample %0d", gv, n, t + DEPTH);
        end
        read_all(100, 1'b0, se, to);
        checks++;
        if (to || se != 0) begin
            failures++;
            $display("FAIL ramp_read: got timeout=%b stall_err=%0d, want 0/0", to, se);
        end
        if (!to && t >= 0 && q1.size() >= t + DEPTH) begin
            for (int k = 0; k < DEPTH; k++) begin
                checks++;
                if (r1[k] !== q1[t+k] || r2[k] !== q2[t+k] || rl[k] !== (k == DEPTH - 1)) begin
                    failures++;
                    $display("FAIL ramp_beat%0d: got %h/%h last=%b, want %h/%h last=%b",
                             k, r1[k], r2[k], rl[k], q1[t+k], q2[t+k], (k == DEPTH - 1));
                end
            end
        end
        if (!to) begin
            checks++;
            if (r1[0] !== 8'h80 || r2[0] !== 8'h7F || r1[DEPTH-1] !== 8'h8F || r2[DEPTH-1] !== 8'h70) begin
                failures++;
                $display("FAIL ramp_ends: got first %h/%h last %h/%h, want 80/7f 8f/70",
                         r1[0], r2[0], r1[DEPTH-1], r2[DEPTH-1]);
            end
        end
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_last !== 1'b0 || rd_data1 !== 8'h00) begin
            failures++;
            $display("FAIL ramp_idle: got valid=%b busy=%b last=%b d1=%h, want 0", rd_valid, busy, rd_last, rd_data1);
        end
    endtask

    task automatic test_en_toggle();
        bit gv, to; int n, t, se;
        logic [DW-1:0] val;
        logic [DW-1:0] junk;
        clear_stim();
        val = 8'h70;
        for (int c = 0; c < 80; c++) begin
            junk = 8'($urandom);
            if (c % 2 == 0) begin
                add_stim(1'b1, val, ~val, 8'h80);
                val++;
            end else begin
                add_stim(1'b0, junk, ~junk ^ 8'h5A, 8'h80);
            end
        end
        do_arm();
        drive_capture(1'b0, gv, n);
        t = find_trig();
        checks++;
        if (!gv || t < 0 || n != t + DEPTH) begin
            failures++;
            $display("FAIL entog_latency: got valid=%b at sample %0d, want 1 at sample %0d", gv, n, t + DEPTH);
        end
        read_all(100, 1'b0, se, to);
        checks++;
        if (to || se != 0) begin
            failures++;
            $display("FAIL entog_read: got timeout=%b stall_err=%0d, want 0/0", to, se);
        end
        if (!to && t >= 0 && q1.size() >= t + DEPTH) begin
            for (int k = 0; k < DEPTH; k++) begin
                checks++;
                if (r1[k] !== q1[t+k] || r2[k] !== q2[t+k] || rl[k] !== (k == DEPTH - 1)) begin
                    failures++;
                    $display("FAIL entog_beat%0d: got %h/%h last=%b, want %h/%h last=%b",
                             k, r1[k], r2[k], rl[k], q1[t+k], q2[t+k], (k == DEPTH - 1));
                end
            end
        end
        if (!to) begin
            checks++;
            if (r1[0] !== 8'h80 || r1[DEPTH-1] !== 8'h8F) begin
                failures++;
                $display("FAIL entog_ends: got %h..%h, want 80..8f", r1[0], r1[DEPTH-1]);
            end
        end
    endtask

    task automatic test_trigger_rules();
        bit gv, to; int n, t, se;
        en = 1'b1; din1 = 8'h10; din2 = 8'h00; trig_level = 8'h80;
        tick(); tick(); tick();
        do_arm();
        clear_stim();
        add_stim(1'b1, 8'h85, 8'h11, 8'h80);
        add_stim(1'b1, 8'h90, 8'h22, 8'h80);
        drive_capture(1'b0, gv, n);
        checks++;
        if (gv || busy !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_trig_above: got valid=%b busy=%b, want valid=0 busy=1", rd_valid, busy);
        end
        clear_stim();
        add_stim(1'b1, 8'h7F, 8'h33, 8'h80);
        add_stim(1'b1, 8'h80, 8'h44, 8'h80);
        for (int c = 0; c < 25; c++) add_stim(1'b1, 8'($urandom), 8'($urandom), 8'h80);
        drive_capture(1'b0, gv, n);
        t = find_trig();
        checks++;
        if (!gv || t < 0 || n != t + DEPTH) begin
            failures++;
            $display("FAIL cross_latency: got valid=%b at sample %0d, want 1 at sample %0d", gv, n, t + DEPTH);
        end
        read_all(100, 1'b0, se, to);
        checks++;
        if (to || r1[0] !== 8'h80 || r2[0] !== 8'h44) begin
            failures++;
            $display("FAIL cross_first: got timeout=%b buf0=%h/%h, want 0 80/44", to, r1[0], r2[0]);
        end
        if (!to && t >= 0 && q1.size() >= t + DEPTH) begin
            for (int k = 0; k < DEPTH; k++) begin
                checks++;
                if (r1[k] !== q1[t+k] || r2[k] !== q2[t+k] || rl[k] !== (k == DEPTH - 1)) begin
                    failures++;
                    $display("FAIL cross_beat%0d: got %h/%h last=%b, want %h/%h last=%b",
                             k, r1[k], r2[k], rl[k], q1[t+k], q2[t+k], (k == DEPTH - 1));
                end
            end
        end
        do_arm();
        clear_stim();
        for (int c = 0; c < 40; c++) add_stim(1'b1, 8'hFF, 8'($urandom), 8'h80);
        drive_capture(1'b0, gv, n);
        checks++;
        if (gv || busy !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL const_level: got valid=%b busy=%b, want valid=0 busy=1", rd_valid, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        bit gv, to, exp_gv; int n, t, se;
        logic [DW-1:0] base;
        for (int it = 0; it < 3; it++) begin
            base = 8'($urandom_range(8'h30, 8'hC0));
            clear_stim();
            for (int c = 0; c < 300; c++)
                add_stim($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
                         base + 8'($urandom_range(0, 15)));
            do_arm();
            drive_capture(1'b1, gv, n);
            t = find_trig();
            exp_gv = (t >= 0) && (q1.size() >= t + DEPTH);
            checks++;
            if (gv !== exp_gv || (gv && n != t + DEPTH)) begin
                failures++;
                $display("FAIL rand%0d_latency: got valid=%b at sample %0d, want %b at sample %0d",
                         it, gv, n, exp_gv, t + DEPTH);
            end
            if (gv) begin
                read_all(50, 1'b1, se, to);
                checks++;
                if (to || se != 0) begin
                    failures++;
                    $display("FAIL rand%0d_stall: got timeout=%b stall_err=%0d, want 0/0", it, to, se);
                end
                if (!to && t >= 0 && q1.size() >= t + DEPTH) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        checks++;
                        if (r1[k] !== q1[t+k] || r2[k] !== q2[t+k] || rl[k] !== (k == DEPTH - 1)) begin
                            failures++;
                            $display("FAIL rand%0d_beat%0d: got %h/%h last=%b, want %h/%h last=%b",
                                     it, k, r1[k], r2[k], rl[k], q1[t+k], q2[t+k], (k == DEPTH - 1));
                        end
                    end
                end
                checks++;
                if (rd_valid !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rand%0d_idle: got valid=%b busy=%b, want 0/0", it, rd_valid, busy);
                end
            end else begin
                rst = 1'b1; tick(); rst = 1'b0; tick();
            end
        end
    endtask

    task automatic test_reset_mid_capture();
        bit gv, to; int n, t, se, hi_cnt;
        clear_stim();
        for (int v = 8'h70; v <= 8'h86; v++) add_stim(1'b1, 8'(v), ~8'(v), 8'h80);
        do_arm();
        drive_capture(1'b0, gv, n);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (gv || busy !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_capture: got early_valid=%b busy=%b valid=%b, want 0/0/0", gv, busy, rd_valid);
        end
        tick();
        rst = 1'b0;
        hi_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (rd_valid !== 1'b0 || busy !== 1'b0) hi_cnt++;
        end
        checks++;
        if (hi_cnt != 0) begin
            failures++;
            $display("FAIL abort_idle: got %0d active cycles, want 0", hi_cnt);
        end
        clear_stim();
        for (int v = 8'h60; v <= 8'hA0; v++) add_stim(1'b1, 8'(v), 8'($urandom), 8'h80);
        do_arm();
        drive_capture(1'b0, gv, n);
        t = find_trig();
        checks++;
        if (!gv || t < 0 || n != t + DEPTH) begin
            failures++;
            $display("FAIL rearm_latency: got valid=%b at sample %0d, want 1 at sample %0d", gv, n, t + DEPTH);
        end
        read_all(100, 1'b0, se, to);
        checks++;
        if (to || r1[0] !== 8'h80 || r1[DEPTH-1] !== 8'h8F) begin
            failures++;
            $display("FAIL rearm_ends: got timeout=%b %h..%h, want 0 80..8f", to, r1[0], r1[DEPTH-1]);
        end
        if (!to && t >= 0 && q1.size() >= t + DEPTH) begin
            for (int k = 0; k < DEPTH; k++) begin
                checks++;
                if (r1[k] !== q1[t+k] || r2[k] !== q2[t+k] || rl[k] !== (k == DEPTH - 1)) begin
                    failures++;
                    $display("FAIL rearm_beat%0d: got %h/%h last=%b, want %h/%h last=%b",
                             k, r1[k], r2[k], rl[k], q1[t+k], q2[t+k], (k == DEPTH - 1));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; arm = 1'b0; rd_ready = 1'b0;
        trig_level = 8'h80; din1 = '0; din2 = '0;
        test_reset();
        test_ramp();
        test_en_toggle();
        test_trigger_rules();
        test_backpressure();
        test_reset_mid_capture();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
